// File: rtl/uart_rx_framer.sv
// 8N1 UART receive framer: two-flop synchroniser, oversampled start-bit check,
// 3-sample majority vote per bit, and one-cycle data_rdy / frame_err strobes.
module uart_rx_framer #(
    parameter int CLK_FREQ   = 12000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       data_rdy,
    output logic       frame_err,
    output logic       rx_busy_o
);

    localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int M   = OVERSAMPLE / 2;
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW  = $clog2(OVERSAMPLE);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t          state_reg;
    logic [1:0]      sync_reg;
    logic [DW-1:0]   div_cnt_reg;
    logic [SW-1:0]   s_cnt_reg;
    logic [2:0]      bit_cnt_reg;
    logic [1:0]      vote_reg;
    logic [7:0]      shift_reg;
    logic [7:0]      data_reg;
    logic            data_rdy_reg;
    logic            frame_err_reg;

    logic rx_s;
    logic tick;
    logic majority;
    logic at_decide;
    logic at_wrap;

    assign rx_s      = sync_reg[1];
    assign tick      = (div_cnt_reg == DW'(DIV - 1));
    // The third vote is the live sample taken on the deciding tick itself.
    assign majority  = (vote_reg[0] & vote_reg[1]) | (vote_reg[0] & rx_s) | (vote_reg[1] & rx_s);
    assign at_decide = tick && (s_cnt_reg == SW'(M + 1));
    assign at_wrap   = tick && (s_cnt_reg == SW'(OVERSAMPLE - 1));

    assign data_o    = data_reg;
    assign data_rdy  = data_rdy_reg;
    assign frame_err = frame_err_reg;
    assign rx_busy_o = (state_reg != IDLE);

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            sync_reg      <= 2'b11;
            div_cnt_reg   <= '0;
            s_cnt_reg     <= '0;
            bit_cnt_reg   <= '0;
            vote_reg      <= '0;
            shift_reg     <= '0;
            data_reg      <= '0;
            data_rdy_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            sync_reg      <= {sync_reg[0], rx_i};
            data_rdy_reg  <= 1'b0;
            frame_err_reg <= 1'b0;

            case (state_reg)
                IDLE: begin
                    // Holding the divider at zero aligns bit phase to the edge.
                    div_cnt_reg <= '0;
                    s_cnt_reg   <= '0;
                    if (!rx_s) begin
                        state_reg <= START;
                    end
                end

                WAIT_HIGH: begin
                    div_cnt_reg <= '0;
                    s_cnt_reg   <= '0;
                    if (rx_s) begin
                        state_reg <= IDLE;
                    end
                end

                default: begin
                    if (tick) begin
                        div_cnt_reg <= '0;
                        s_cnt_reg   <= at_wrap ? '0 : s_cnt_reg + 1'b1;
                        if (s_cnt_reg == SW'(M - 1)) begin
                            vote_reg[0] <= rx_s;
                        end
                        if (s_cnt_reg == SW'(M)) begin
                            vote_reg[1] <= rx_s;
                        end
                    end else begin
                        div_cnt_reg <= div_cnt_reg + 1'b1;
                    end

                    case (state_reg)
                        START: begin
                            if (at_decide && majority) begin
                                state_reg <= IDLE;
                            end else if (at_wrap) begin
                                state_reg   <= DATA;
                                bit_cnt_reg <= '0;
                            end
                        end
                        DATA: begin
                            if (at_decide) begin
                                shift_reg <= {majority, shift_reg[7:1]};
                            end
                            if (at_wrap) begin
                                if (bit_cnt_reg == 3'd7) begin
                                    state_reg <= STOP;
                                end
                                bit_cnt_reg <= bit_cnt_reg + 1'b1;
                            end
                        end
                        STOP: begin
                            // Leave at mid stop bit so a back-to-back start edge is caught.
                            if (at_decide) begin
                                if (majority) begin
                                    data_reg     <= shift_reg;
                                    data_rdy_reg <= 1'b1;
                                    state_reg    <= IDLE;
                                end else begin
                                    frame_err_reg <= 1'b1;
                                    state_reg     <= WAIT_HIGH;
                                end
                            end
                        end
                        default: begin
                            state_reg <= IDLE;
                        end
                    endcase
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_framer.sv
// Directed plus randomized frames against a byte-level model of 8N1 reception
// with DIV=4 (64 clk per bit).
module tb_uart_rx_framer;

    localparam int BAUD     = 9600;
    localparam int OS       = 16;
    localparam int DIV      = 4;
    localparam int CLK_FREQ = OS * BAUD * DIV;
    localparam int BITC     = OS * DIV;
    localparam int FRAMEC   = 10 * BITC;

    logic       clk_in = 1'b0;
    logic       reset  = 1'b0;
    logic       rx_i   = 1'b1;
    logic [7:0] data_o;
    logic       data_rdy;
    logic       frame_err;
    logic       rx_busy_o;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int unsigned start_t = 0;

    logic [7:0]  rdy_q[$];
    int unsigned rdy_t[$];
    int          ferr_cnt = 0;
    int          both_cnt = 0;
    int          chg_cnt  = 0;
    logic [7:0]  prev_data = 8'h00;

    uart_rx_framer #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .OVERSAMPLE(OS)
    ) dut (
        .clk_in   (clk_in),
        .reset    (reset),
        .rx_i     (rx_i),
        .data_o   (data_o),
        .data_rdy (data_rdy),
        .frame_err(frame_err),
        .rx_busy_o(rx_busy_o)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    always @(negedge clk_in) begin
        if (data_rdy) begin
            rdy_q.push_back(data_o);
            rdy_t.push_back(cyc);
            $display("cyc %0d: data_rdy byte 0x%02h", cyc, data_o);
        end
        if (frame_err) begin
            ferr_cnt <= ferr_cnt + 1;
            $display("cyc %0d: frame_err strobe", cyc);
        end
        if (data_rdy && frame_err) both_cnt <= both_cnt + 1;
        if (reset && (data_o !== prev_data) && !data_rdy) chg_cnt <= chg_cnt + 1;
        prev_data <= data_o;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drives len clk of an 8N1 frame; noise_at >= 0 inverts the line for one tick.
    task automatic drive_frame(input logic [7:0] b, input logic stop, input int noise_at, input int len);
        for (int i = 0; i < len; i++) begin
            int   bp;
            logic v;
            bp = i / BITC;
            if (bp == 0) v = 1'b0;
            else if (bp <= 8) v = b[bp-1];
            else v = stop;
            if (noise_at >= 0 && i >= noise_at && i < noise_at + DIV) v = ~v;
            @(negedge clk_in);
            rx_i = v;
            if (i == 0) start_t = cyc;
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk_in);
        rx_i = 1'b1;
        repeat (n) @(negedge clk_in);
    endtask

    initial begin
        int          n0;
        int          f0;
        int unsigned lat;
        int unsigned gap;
        logic [7:0]  btb[3];
        logic [7:0]  exp_q[$];
        logic [7:0]  rb;

        btb[0] = 8'h6A; btb[1] = 8'h12; btb[2] = 8'h34;

        repeat (3) @(negedge clk_in);
        chk("reset_data_o", data_o, 8'h00);
        chk("reset_data_rdy", data_rdy, 1'b0);
        chk("reset_frame_err", frame_err, 1'b0);
        chk("reset_busy", rx_busy_o, 1'b0);
        reset = 1'b1;
        idle(20);

        // Single clean frame and its latency from the start edge
        n0 = rdy_q.size(); f0 = ferr_cnt;
        drive_frame(8'h61, 1'b1, -1, FRAMEC);
        idle(16);
        chk("t1_count", rdy_q.size(), n0 + 1);
        if (rdy_q.size() == n0 + 1) begin
            chk("t1_byte", rdy_q[n0], 8'h61);
            lat = rdy_t[n0] - start_t;
            $display("t1 latency %0d clk", lat);
            chk("t1_latency_in_614_623", (lat >= 614 && lat <= 623), 1'b1);
        end
        chk("t1_no_ferr", ferr_cnt, f0);
        chk("t1_busy_low", rx_busy_o, 1'b0);

        // Back-to-back frames, one stop bit each
        n0 = rdy_q.size();
        for (int k = 0; k < 3; k++) drive_frame(btb[k], 1'b1, -1, FRAMEC);
        idle(16);
        chk("t2_count", rdy_q.size(), n0 + 3);
        if (rdy_q.size() == n0 + 3) begin
            for (int k = 0; k < 3; k++) chk("t2_byte", rdy_q[n0+k], btb[k]);
            for (int k = 1; k < 3; k++) begin
                gap = rdy_t[n0+k] - rdy_t[n0+k-1];
                chk("t2_spacing_636_644", (gap >= 636 && gap <= 644), 1'b1);
            end
        end

        // 20 clk low glitch on idle line
        n0 = rdy_q.size(); f0 = ferr_cnt;
        @(negedge clk_in); rx_i = 1'b0;
        repeat (20) @(negedge clk_in);
        idle(100);
        chk("t3_no_rdy", rdy_q.size(), n0);
        chk("t3_no_ferr", ferr_cnt, f0);
        chk("t3_busy_low", rx_busy_o, 1'b0);

        // Stop bit low, then a break, then a good frame
        n0 = rdy_q.size(); f0 = ferr_cnt;
        drive_frame(8'h55, 1'b0, -1, FRAMEC);
        repeat (200) @(negedge clk_in);
        chk("t4_busy_in_break", rx_busy_o, 1'b1);
        idle(64);
        chk("t4_one_ferr", ferr_cnt, f0 + 1);
        chk("t4_no_rdy", rdy_q.size(), n0);
        chk("t4_data_held", data_o, 8'h34);
        drive_frame(8'h70, 1'b1, -1, FRAMEC);
        idle(16);
        chk("t4_count", rdy_q.size(), n0 + 1);
        chk("t4_data_after", data_o, 8'h70);

        // One-tick noise at the centre vote of bit 3
        n0 = rdy_q.size();
        drive_frame(8'hA5, 1'b1, 4 * BITC + 35, FRAMEC);
        idle(16);
        chk("t5_count", rdy_q.size(), n0 + 1);
        chk("t5_data", data_o, 8'hA5);

        // Random bytes, each with centre-vote noise on a random data bit
        n0 = rdy_q.size();
        for (int k = 0; k < 4; k++) begin
            rb = 8'($urandom);
            exp_q.push_back(rb);
            drive_frame(rb, 1'b1, BITC * (1 + int'($urandom_range(7, 0))) + 35, FRAMEC);
        end
        idle(16);
        chk("rnd_count", rdy_q.size(), n0 + 4);
        if (rdy_q.size() == n0 + 4) begin
            for (int k = 0; k < 4; k++) chk("rnd_byte", rdy_q[n0+k], exp_q[k]);
        end

        // Reset mid-frame, then a fresh frame
        n0 = rdy_q.size(); f0 = ferr_cnt;
        drive_frame(8'h7F, 1'b1, -1, 5 * BITC);
        chk("t6_busy_mid", rx_busy_o, 1'b1);
        reset = 1'b0;
        repeat (3) @(negedge clk_in);
        reset = 1'b1;
        rx_i  = 1'b1;
        chk("t6_data_reset", data_o, 8'h00);
        chk("t6_busy_reset", rx_busy_o, 1'b0);
        idle(FRAMEC);
        chk("t6_no_rdy", rdy_q.size(), n0);
        chk("t6_no_ferr", ferr_cnt, f0);
        chk("t6_data_still_zero", data_o, 8'h00);
        drive_frame(8'h73, 1'b1, -1, FRAMEC);
        idle(16);
        chk("t6_count", rdy_q.size(), n0 + 1);
        chk("t6_data", data_o, 8'h73);

        chk("never_rdy_and_ferr", both_cnt, 0);
        chk("data_o_only_on_rdy", chg_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
